// File: rtl/sec_timer_pkg.sv
// Shared types and constants for the seconds timer: FSM states, blank segment
// pattern and the hex-to-7-segment lookup table (active-low, gfedcba order).
package sec_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} tmr_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational 4-bit digit to active-low 7-segment (gfedcba) decoder.
module bcd_to_7seg
    import sec_timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_lookup(bcd);

endmodule

// File: rtl/sec_tick_timer.sv
// Seconds counter driven by a 1 Hz enable pulse, with start/pause/clear control,
// binary and BCD outputs. Define SEVEN_SEG_EN to add registered hex0/hex1 outputs.
module sec_tick_timer
    import sec_timer_pkg::*;
#(
    parameter int MAX_SEC = 59,
    parameter int SEC_W   = 7
) (
    input  logic             CLOCK,
    input  logic             clr,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             sclr,
    input  logic [SEC_W-1:0] limit,
    output logic [SEC_W-1:0] sec,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic             running,
    output logic             done,
    output tmr_state_t       state
`ifdef SEVEN_SEG_EN
    ,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
`endif
);

    localparam logic [SEC_W-1:0] MAX_V = SEC_W'(MAX_SEC);

    tmr_state_t       state_q, state_n;
    logic [SEC_W-1:0] sec_q, sec_n;
    logic [SEC_W-1:0] lim_q, lim_n;
    logic [SEC_W-1:0] sec_inc;
    logic [3:0]       ones_q, ones_n;
    logic [3:0]       tens_q, tens_n;
    logic             running_q, done_q;

    assign sec_inc = sec_q + 1'b1;

    always_ff @(posedge CLOCK or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            lim_q     <= MAX_V;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            sec_q     <= sec_n;
            ones_q    <= ones_n;
            tens_q    <= tens_n;
            lim_q     <= lim_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == DONE);
        end
    end

    // Priority: sclr > pause > start > tick. A start from IDLE/DONE swallows a
    // coincident tick because the counts are zeroed on that edge.
    always_comb begin
        state_n = state_q;
        sec_n   = sec_q;
        ones_n  = ones_q;
        tens_n  = tens_q;
        lim_n   = lim_q;
        if (sclr) begin
            state_n = IDLE;
            sec_n   = '0;
            ones_n  = '0;
            tens_n  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = RUN;
                        sec_n   = '0;
                        ones_n  = '0;
                        tens_n  = '0;
                        lim_n   = (limit == '0 || limit > MAX_V) ? MAX_V : limit;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        sec_n = sec_inc;
                        if (ones_q == 4'd9) begin
                            ones_n = 4'd0;
                            tens_n = tens_q + 4'd1;
                        end else begin
                            ones_n = ones_q + 4'd1;
                        end
                        if (sec_inc == lim_q) begin
                            state_n = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_n = RUN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sec     = sec_q;
    assign ones    = ones_q;
    assign tens    = tens_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

`ifdef SEVEN_SEG_EN
    logic [6:0] seg0, seg1;
    logic [6:0] hex0_q, hex1_q;

    bcd_to_7seg u_seg0 (.bcd(ones_q), .seg(seg0));
    bcd_to_7seg u_seg1 (.bcd(tens_q), .seg(seg1));

    // Registered decode: segments trail the BCD digits by one cycle.
    always_ff @(posedge CLOCK or posedge clr) begin
        if (clr) begin
            hex0_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
        end else begin
            hex0_q <= seg0;
            hex1_q <= seg1;
        end
    end

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
`endif

endmodule

// File: tb/tb_sec_tick_timer.sv
// Directed bench for sec_tick_timer: drivers push each expected output change
// into a queue; a monitor pops and compares whenever the outputs change.
module tb_sec_tick_timer;
    import sec_timer_pkg::*;

    logic       CLOCK = 1'b0;
    logic       clr   = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       sclr  = 1'b0;
    logic [6:0] limit = 7'd0;
    logic [6:0] sec;
    logic [3:0] ones, tens;
    logic       running, done;
    tmr_state_t state_w;
`ifdef SEVEN_SEG_EN
    logic [6:0] hex0, hex1;
`endif

    sec_tick_timer #(.MAX_SEC(59), .SEC_W(7)) dut (
        .CLOCK(CLOCK), .clr(clr), .tick(tick), .start(start), .pause(pause),
        .sclr(sclr), .limit(limit), .sec(sec), .ones(ones), .tens(tens),
        .running(running), .done(done), .state(state_w)
`ifdef SEVEN_SEG_EN
        , .hex0(hex0), .hex1(hex1)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #10 CLOCK = ~CLOCK;

    initial begin
        #200_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] pk(input tmr_state_t st, input int s);
        logic [6:0] sv;
        logic [3:0] o, t;
        sv = 7'(s);
        o  = 4'(s % 10);
        t  = 4'(s / 10);
        return {st, sv, o, t, (st == RUN), (st == DONE)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input tmr_state_t st, input int s);
        exp_q.push_back(pk(st, s));
    endtask

    logic [18:0] obs, prev_obs, want;
    initial prev_obs = '0;

    always @(negedge CLOCK) begin
        obs = {state_w, sec, ones, tens, running, done};
        if (!clr && obs !== prev_obs) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL seq_unexpected: got %h (sec=%0d) want no change", obs, obs[16:10]);
            end else begin
                want = exp_q.pop_front();
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL seq: got %h (sec=%0d ones=%0d tens=%0d) want %h (sec=%0d ones=%0d tens=%0d)",
                             obs, obs[16:10], obs[9:6], obs[5:2], want, want[16:10], want[9:6], want[5:2]);
                end
            end
        end
        prev_obs = obs;
    end

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_start(input logic [6:0] lim);
        limit = lim;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(4);
    endtask

    task automatic run_to_done(input logic [6:0] lim, input int target);
        push(RUN, 0);
        do_start(lim);
        for (int k = 1; k <= target; k++) begin
            push((k == target) ? DONE : RUN, k);
            do_tick();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sec"}, 32'(sec), 0);
        chk({tag, "_ones"}, 32'(ones), 0);
        chk({tag, "_tens"}, 32'(tens), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_state"}, 32'(state_w), 32'(IDLE));
`ifdef SEVEN_SEG_EN
        chk({tag, "_hex0"}, 32'(hex0), 32'h7F);
        chk({tag, "_hex1"}, 32'(hex1), 32'h7F);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc(3);
        chk_reset_vals("reset");
        clr = 1'b0;
        cyc(2);

        // T2: limit 7, 7 ticks to DONE, 3 extra ticks ignored
        run_to_done(7'd7, 7);
        repeat (3) do_tick();
        chk("t2_hold_sec", 32'(sec), 7);
        chk("t2_hold_done", 32'(done), 1);

        // T6: restart from DONE with limit 2
        run_to_done(7'd2, 2);

        // T3: limit 12, BCD carry at 10
        push(RUN, 0);
        do_start(7'd12);
        for (int k = 1; k <= 12; k++) begin
            push((k == 12) ? DONE : RUN, k);
            do_tick();
            if (k == 10) begin
                chk("t3_ones_at10", 32'(ones), 0);
                chk("t3_tens_at10", 32'(tens), 1);
            end
        end
        chk("t3_done_ones", 32'(ones), 2);
        chk("t3_done_tens", 32'(tens), 1);

        // T5: limit 0 and limit 99 both clamp to 59
        run_to_done(7'd0, 59);
        chk("t5a_ones", 32'(ones), 9);
        chk("t5a_tens", 32'(tens), 5);
        run_to_done(7'd99, 59);
        chk("t5b_done", 32'(done), 1);

        // T4: pause coincident with tick, ticks in PAUSE ignored, resume
        push(RUN, 0);
        do_start(7'd20);
        for (int k = 1; k <= 4; k++) begin
            push(RUN, k);
            do_tick();
        end
        push(PAUSE, 4);
        pause = 1'b1;
        tick  = 1'b1;
        cyc(1);
        pause = 1'b0;
        tick  = 1'b0;
        cyc(4);
        repeat (3) do_tick();
        chk("t4_paused_sec", 32'(sec), 4);
        push(RUN, 4);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        push(RUN, 5);
        do_tick();
        chk("t4_resume_sec", 32'(sec), 5);

        // T6b: sclr with start and tick together returns to IDLE
        push(IDLE, 0);
        sclr  = 1'b1;
        start = 1'b1;
        tick  = 1'b1;
        cyc(1);
        sclr  = 1'b0;
        start = 1'b0;
        tick  = 1'b0;
        cyc(1);
        chk("t6_sclr_state", 32'(state_w), 32'(IDLE));
        chk("t6_sclr_sec", 32'(sec), 0);

        // T1: async clr mid-RUN at sec 3
        push(RUN, 0);
        do_start(7'd20);
        for (int k = 1; k <= 3; k++) begin
            push(RUN, k);
            do_tick();
        end
        #3;
        clr = 1'b1;
        #1;
        chk_reset_vals("t1_clr");
        cyc(2);
        clr = 1'b0;
        cyc(3);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
